// File: rtl/fractal_frame_buf.sv
// Fractal frame buffer: (x,y) write port with range checking, linear registered
// read port, and a fill engine that clears the whole frame to a programmable value.
module fractal_frame_buf #(
    parameter  int unsigned H_RES  = 640,
    parameter  int unsigned V_RES  = 480,
    parameter  int unsigned PIX_W  = 4,
    localparam int unsigned DEPTH  = H_RES * V_RES,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned X_W    = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int unsigned Y_W    = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    input  logic [PIX_W-1:0]  wr_pixel,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_pixel,
    output logic              rd_valid,
    input  logic              clear_start,
    input  logic [PIX_W-1:0]  clear_value,
    output logic              busy,
    output logic              clear_done,
    output logic              oob_err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [PIX_W-1:0]    clr_val_q, clr_val_d;
    logic                oob_q, oob_d;
    logic [PIX_W-1:0]    rd_pixel_q;
    logic                rd_valid_q;

    logic [PIX_W-1:0]    mem_q [DEPTH];

    logic                wr_acc_c;
    logic                wr_oob_c;
    logic [ADDR_W-1:0]   wr_addr_c;
    logic                last_c;
    logic                rd_in_range_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_waddr_c;
    logic [PIX_W-1:0]    mem_wdata_c;

    // Range check is done on the coordinates, so the address is only used when it fits.
    assign wr_acc_c      = wr_valid && (state_q == IDLE);
    assign wr_oob_c      = (32'(wr_x) >= H_RES) || (32'(wr_y) >= V_RES);
    assign wr_addr_c     = ADDR_W'(wr_y) * ADDR_W'(H_RES) + ADDR_W'(wr_x);
    assign last_c        = (state_q == CLEAR) && (cnt_q == ADDR_W'(DEPTH - 1));
    assign rd_in_range_c = (32'(rd_addr) < DEPTH);

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clr_val_q <= '0;
            oob_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_val_q <= clr_val_d;
            oob_q     <= oob_d;
        end
    end

    // Next-state: clear sequencing and sticky out-of-range flag
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_val_d = clr_val_q;
        oob_d     = oob_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    cnt_d     = '0;
                    clr_val_d = clear_value;
                end
            end
            CLEAR: begin
                if (last_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr_acc_c && wr_oob_c) begin
            oob_d = 1'b1;
        end
    end

    // Single memory write port shared by the fill engine and the pixel writer
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_addr_c;
        mem_wdata_c = wr_pixel;
        if (state_q == CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cnt_q;
            mem_wdata_c = clr_val_q;
        end else if (wr_acc_c && !wr_oob_c) begin
            mem_we_c = 1'b1;
        end
    end

    // Pixel array has no reset; it is filled by the clear engine before use
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Registered read port; sees pre-write contents on a same-edge collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pixel_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_pixel_q <= rd_in_range_c ? mem_q[rd_addr] : '0;
            end
        end
    end

    assign wr_ready   = (state_q == IDLE);
    assign busy       = (state_q == CLEAR);
    assign clear_done = last_c;
    assign oob_err    = oob_q;
    assign rd_pixel   = rd_pixel_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_fractal_frame_buf.sv
// Bench for fractal_frame_buf: an 8x4 frame for the main flows and a 6x3 frame whose
// non-power-of-two size makes out-of-range coordinates and addresses reachable.
module tb_fractal_frame_buf;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned D  = H * V;
    localparam int unsigned SH = 6;
    localparam int unsigned SV = 3;
    localparam int unsigned SD = SH * SV;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       wr_valid, wr_ready, rd_en, rd_valid, clear_start, busy, clear_done, oob_err;
    logic [2:0] wr_x;
    logic [1:0] wr_y;
    logic [3:0] wr_pixel, rd_pixel, clear_value;
    logic [4:0] rd_addr;

    logic       s_wr_valid, s_wr_ready, s_rd_en, s_rd_valid, s_clear_start, s_busy, s_clear_done, s_oob_err;
    logic [2:0] s_wr_x;
    logic [1:0] s_wr_y;
    logic [3:0] s_wr_pixel, s_rd_pixel, s_clear_value;
    logic [4:0] s_rd_addr;

    fractal_frame_buf #(.H_RES(H), .V_RES(V), .PIX_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_pixel(rd_pixel), .rd_valid(rd_valid),
        .clear_start(clear_start), .clear_value(clear_value),
        .busy(busy), .clear_done(clear_done), .oob_err(oob_err)
    );

    fractal_frame_buf #(.H_RES(SH), .V_RES(SV), .PIX_W(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_x(s_wr_x), .wr_y(s_wr_y), .wr_pixel(s_wr_pixel),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_pixel(s_rd_pixel), .rd_valid(s_rd_valid),
        .clear_start(s_clear_start), .clear_value(s_clear_value),
        .busy(s_busy), .clear_done(s_clear_done), .oob_err(s_oob_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] model  [D];
    logic [3:0] smodel [SD];

    int         cyc, dones, rdy_hi;
    logic [3:0] exp_pix;
    logic       exp_v;
    logic [4:0] waddr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [4:0] a, input logic [3:0] e, input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check_eq({tag, "_pix"}, 32'(rd_pixel), 32'(e));
    endtask

    task automatic s_read_chk(input logic [4:0] a, input logic [3:0] e, input string tag);
        s_rd_en   = 1'b1;
        s_rd_addr = a;
        tick();
        s_rd_en   = 1'b0;
        check_eq({tag, "_valid"}, 32'(s_rd_valid), 32'd1);
        check_eq({tag, "_pix"}, 32'(s_rd_pixel), 32'(e));
    endtask

    task automatic wr_pix(input logic [2:0] x, input logic [1:0] y, input logic [3:0] p);
        wr_valid = 1'b1; wr_x = x; wr_y = y; wr_pixel = p;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic s_wr_pix(input logic [2:0] x, input logic [1:0] y, input logic [3:0] p);
        s_wr_valid = 1'b1; s_wr_x = x; s_wr_y = y; s_wr_pixel = p;
        tick();
        s_wr_valid = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < int'(D); a++) read_chk(5'(a), model[a], tag);
    endtask

    // Runs one clear on the main frame; optional mid-clear restart attempt and early probe read
    task automatic run_clear(input logic [3:0] val, input int restart_at, input int probe,
                             input logic [3:0] probe_exp);
        clear_start = 1'b1;
        clear_value = val;
        tick();
        clear_start = 1'b0;
        clear_value = 4'h0;
        cyc = 0; dones = 0; rdy_hi = 0;
        while (busy && cyc < 100) begin
            if (clear_done) dones++;
            if (wr_ready) rdy_hi++;
            if (probe >= 0 && cyc == 0) begin
                rd_en = 1'b1; rd_addr = 5'(probe);
            end
            if (probe >= 0 && cyc == 1) begin
                rd_en = 1'b0;
                check_eq("clr_probe_pix", 32'(rd_pixel), 32'(probe_exp));
            end
            cyc++;
            if (cyc == restart_at) begin
                clear_start = 1'b1; clear_value = 4'h5;
            end else begin
                clear_start = 1'b0;
            end
            tick();
        end
        clear_start = 1'b0;
        rd_en = 1'b0;
        check_eq("clr_cycles", 32'(cyc), 32'(D));
        check_eq("clr_done_cnt", 32'(dones), 32'd1);
        check_eq("clr_rdy_low", 32'(rdy_hi), 32'd0);
        check_eq("clr_rdy_after", 32'(wr_ready), 32'd1);
        for (int a = 0; a < int'(D); a++) model[a] = val;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_pixel = 0; rd_en = 0; rd_addr = 0;
        clear_start = 0; clear_value = 0;
        s_wr_valid = 0; s_wr_x = 0; s_wr_y = 0; s_wr_pixel = 0; s_rd_en = 0; s_rd_addr = 0;
        s_clear_start = 0; s_clear_value = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(clear_done), 32'd0);
        check_eq("rst_rd_pix", 32'(rd_pixel), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_oob", 32'(oob_err), 32'd0);
        check_eq("rst_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: full clear to 3
        run_clear(4'h3, 0, -1, 4'h0);
        read_all("t1_rd");

        // 2: single pixel write and neighbours
        wr_pix(3'd5, 2'd2, 4'hA);
        model[21] = 4'hA;
        read_chk(5'd21, 4'hA, "t2_a21");
        read_chk(5'd20, 4'h3, "t2_a20");
        read_chk(5'd22, 4'h3, "t2_a22");
        check_eq("t2_oob", 32'(oob_err), 32'd0);

        // 3: out-of-range writes and reads on the 6x3 frame
        s_clear_start = 1'b1; s_clear_value = 4'h2;
        tick();
        s_clear_start = 1'b0;
        cyc = 0; dones = 0;
        while (s_busy && cyc < 100) begin
            if (s_clear_done) dones++;
            cyc++;
            tick();
        end
        check_eq("t3_s_cycles", 32'(cyc), 32'(SD));
        check_eq("t3_s_dones", 32'(dones), 32'd1);
        for (int a = 0; a < int'(SD); a++) smodel[a] = 4'h2;
        check_eq("t3_s_oob0", 32'(s_oob_err), 32'd0);
        s_wr_pix(3'd6, 2'd0, 4'hF);
        check_eq("t3_s_oob_x", 32'(s_oob_err), 32'd1);
        s_wr_pix(3'd1, 2'd3, 4'hF);
        s_wr_pix(3'd5, 2'd2, 4'hA);
        smodel[17] = 4'hA;
        repeat (3) tick();
        check_eq("t3_s_oob_sticky", 32'(s_oob_err), 32'd1);
        s_read_chk(5'd6, smodel[6], "t3_s_a6");
        s_read_chk(5'd0, smodel[0], "t3_s_a0");
        s_read_chk(5'd17, smodel[17], "t3_s_a17");
        s_read_chk(5'd18, 4'h0, "t3_s_a18");
        s_read_chk(5'd20, 4'h0, "t3_s_a20");
        s_read_chk(5'd31, 4'h0, "t3_s_a31");
        check_eq("t3_main_oob", 32'(oob_err), 32'd0);

        // 4: read-before-write on the same edge
        wr_valid = 1'b1; wr_x = 3'd5; wr_y = 2'd2; wr_pixel = 4'h7;
        rd_en = 1'b1; rd_addr = 5'd21;
        tick();
        wr_valid = 1'b0; rd_en = 1'b0;
        check_eq("t4_rbw_pix", 32'(rd_pixel), 32'hA);
        model[21] = 4'h7;
        read_chk(5'd21, 4'h7, "t4_after");

        // 5: write coincident with clear_start, restart attempt mid-clear
        wr_valid = 1'b1; wr_x = 3'd7; wr_y = 2'd3; wr_pixel = 4'h9;
        run_clear(4'h0, 10, 31, 4'h9);
        wr_valid = 1'b0;
        read_all("t5_rd");

        // 6: reset in the middle of a clear
        clear_start = 1'b1; clear_value = 4'h5;
        tick();
        clear_start = 1'b0;
        rd_en = 1'b1; rd_addr = 5'd0;
        repeat (10) tick();
        check_eq("t6_pre_busy", 32'(busy), 32'd1);
        check_eq("t6_pre_valid", 32'(rd_valid), 32'd1);
        check_eq("t6_pre_pix", 32'(rd_pixel), 32'h5);
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_valid", 32'(rd_valid), 32'd0);
        check_eq("t6_pix", 32'(rd_pixel), 32'd0);
        check_eq("t6_s_oob_clr", 32'(s_oob_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("t6_ready", 32'(wr_ready), 32'd1);
        check_eq("t6_done", 32'(clear_done), 32'd0);
        for (int a = 0; a < 10; a++) model[a] = 4'h5;
        read_all("t6_rd");

        // Random mixed traffic against the array model
        for (int i = 0; i < 300; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_x     = 3'($urandom);
            wr_y     = 2'($urandom);
            wr_pixel = 4'($urandom);
            waddr    = 5'(int'(wr_y) * int'(H) + int'(wr_x));
            rd_en    = (i == 0) || ($urandom_range(0, 2) != 0);
            rd_addr  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            exp_v    = rd_en;
            if (rd_en) exp_pix = model[rd_addr];
            if (wr_valid) model[waddr] = wr_pixel;
            tick();
            check_eq("rnd_valid", 32'(rd_valid), 32'(exp_v));
            check_eq("rnd_pix", 32'(rd_pixel), 32'(exp_pix));
        end
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        check_eq("rnd_oob", 32'(oob_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
